// File: rtl/dcm_prog_responder.sv
// Slave end of the DCM_CLKGEN serial program port: decodes LoadM/LoadD/GO frames,
// holds pending M/D and commits them after a programmable PROGDONE latency.
//
// state | meaning
// IDLE  | waiting for a frame start
// GO1   | first bit was 0; a GO frame if progen drops now
// CMD   | second header bit selects M (1) or D (0)
// SHIFT | collecting 8 data bits, LSB first
// CHECK | length check and code validation after the last data bit
// DRAIN | discarding the rest of a rejected frame
// APPLY | progdone low, counting down to the commit
module dcm_prog_responder #(
  parameter int M_INIT   = 2,
  parameter int D_INIT   = 3,
  parameter int DONE_LAT = 16
) (
  input  logic       clk50m,
  input  logic       reset_n,
  input  logic       progen,
  input  logic       progdata,
  output logic       progdone,
  output logic [8:0] m_value,
  output logic [8:0] d_value,
  output logic       apply,
  output logic       frame_err
);

  localparam int LW = $clog2(DONE_LAT + 1);
  localparam logic [8:0] M_RST = 9'(M_INIT);
  localparam logic [8:0] D_RST = 9'(D_INIT);
  localparam logic [LW-1:0] LAT_LOAD = LW'(DONE_LAT - 1);

  typedef enum logic [2:0] {IDLE, GO1, CMD, SHIFT, CHECK, DRAIN, APPLY} state_t;

  state_t          state;
  logic            sel;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [LW-1:0]   lat_cnt;
  logic            ign;
  logic [8:0]      m_pend;
  logic [8:0]      d_pend;

  always_ff @(posedge clk50m) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      lat_cnt   <= '0;
      ign       <= 1'b0;
      m_pend    <= M_RST;
      d_pend    <= D_RST;
      m_value   <= M_RST;
      d_value   <= D_RST;
      progdone  <= 1'b1;
      apply     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      apply     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (progen) state <= progdata ? CMD : GO1;
        end
        GO1: begin
          if (progen) begin
            state     <= DRAIN;
            frame_err <= 1'b1;
          end else begin
            state    <= APPLY;
            progdone <= 1'b0;
            lat_cnt  <= LAT_LOAD;
            ign      <= 1'b0;
          end
        end
        CMD: begin
          if (!progen) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else begin
            sel     <= progdata;
            bit_cnt <= 3'd7;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!progen) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else begin
            shreg <= {progdata, shreg[7:1]};
            if (bit_cnt == 3'd0) state <= CHECK;
            else bit_cnt <= bit_cnt - 3'd1;
          end
        end
        CHECK: begin
          if (progen) begin
            state     <= DRAIN;
            frame_err <= 1'b1;
          end else begin
            state <= IDLE;
            if (sel && shreg == 8'd0) frame_err <= 1'b1;
            else if (sel) m_pend <= {1'b0, shreg} + 9'd1;
            else d_pend <= {1'b0, shreg} + 9'd1;
          end
        end
        DRAIN: begin
          if (!progen) state <= IDLE;
        end
        APPLY: begin
          // ign marks a frame already flagged, so each intruding frame errors once
          ign <= progen;
          if (progen && !ign) frame_err <= 1'b1;
          if (lat_cnt == '0) begin
            m_value  <= m_pend;
            d_value  <= d_pend;
            apply    <= 1'b1;
            progdone <= 1'b1;
            state    <= progen ? DRAIN : IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Scoreboard bench for dcm_prog_responder: GO frames push expected M/D,
// apply pulses pop and compare; frame_err pulses are counted against the model.
module tb_dcm_prog_responder;

  localparam int LAT = 16;

  logic       clk50m = 1'b0;
  logic       reset_n = 1'b0;
  logic       progen = 1'b0;
  logic       progdata = 1'b0;
  logic       progdone;
  logic [8:0] m_value;
  logic [8:0] d_value;
  logic       apply;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int apply_seen = 0;
  int apply_exp = 0;
  int err_seen = 0;
  int err_exp = 0;
  int low_run = 0;
  logic [8:0] m_pend = 9'd2;
  logic [8:0] d_pend = 9'd3;
  logic [17:0] exp_q[$];

  dcm_prog_responder #(.M_INIT(2), .D_INIT(3), .DONE_LAT(LAT)) dut (
    .clk50m(clk50m), .reset_n(reset_n), .progen(progen), .progdata(progdata),
    .progdone(progdone), .m_value(m_value), .d_value(d_value),
    .apply(apply), .frame_err(frame_err)
  );

  always #10 clk50m = ~clk50m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk50m) begin
    if (frame_err) err_seen++;
    if (!reset_n) low_run = 0;
    else if (!progdone) low_run++;
    else if (low_run > 0) begin
      chk("done_low_cycles", low_run, LAT);
      low_run = 0;
    end
    if (apply && reset_n) begin
      apply_seen++;
      chk("progdone_at_apply", {31'd0, progdone}, 1);
      if (exp_q.size() == 0) chk("apply_unexpected", 1, 0);
      else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("m_value", {23'd0, m_value}, {23'd0, e[17:9]});
        chk("d_value", {23'd0, d_value}, {23'd0, e[8:0]});
      end
    end
  end

  task automatic cyc(input logic en, input logic dat);
    @(posedge clk50m); #1;
    progen = en;
    progdata = dat;
  endtask

  // header 1,sel then nbits data bits (LSB first), extra over-length cycles, one gap
  task automatic load(input logic is_m, input logic [7:0] code, input int nbits, input int extra);
    cyc(1'b1, 1'b1);
    cyc(1'b1, is_m);
    for (int i = 0; i < nbits; i++) cyc(1'b1, code[i]);
    for (int i = 0; i < extra; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic go_start();
    exp_q.push_back({m_pend, d_pend});
    apply_exp++;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (apply_seen != apply_exp && n < 4 * LAT) begin
      @(posedge clk50m);
      n++;
    end
    chk("apply_count", apply_seen, apply_exp);
    repeat (2) @(posedge clk50m);
  endtask

  task automatic err_check(input string tag);
    repeat (3) @(posedge clk50m);
    chk(tag, err_seen, err_exp);
  endtask

  initial begin
    repeat (3) @(posedge clk50m);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50m);
      chk("reset_idle", {13'd0, progdone, apply, frame_err, m_value, d_value},
          {13'd0, 1'b1, 1'b0, 1'b0, 9'd2, 9'd3});
    end

    load(1'b1, 8'd24, 8, 0); m_pend = 9'd25;
    load(1'b0, 8'd9, 8, 0);  d_pend = 9'd10;
    err_check("err_after_loads");
    go_start();
    wait_done();

    load(1'b1, 8'hFF, 8, 0); m_pend = 9'h100;
    go_start();
    wait_done();

    load(1'b0, 8'h77, 5, 0); err_exp++;
    err_check("err_trunc_d");
    go_start();
    wait_done();

    load(1'b1, 8'd0, 8, 0); err_exp++;
    err_check("err_m_zero");
    load(1'b1, 8'h30, 8, 1); err_exp++;
    err_check("err_long_frame");
    go_start();
    wait_done();

    go_start();
    repeat (3) @(posedge clk50m);
    load(1'b1, 8'h10, 8, 0); err_exp++;
    wait_done();
    chk("err_during_apply", err_seen, err_exp);
    go_start();
    wait_done();

    load(1'b1, 8'd5, 8, 0); m_pend = 9'd6;
    go_start();
    repeat (7) @(posedge clk50m);
    #1 reset_n = 1'b0;
    @(posedge clk50m); #1 reset_n = 1'b1;
    chk("rst_progdone", {31'd0, progdone}, 1);
    chk("rst_m", {23'd0, m_value}, 2);
    chk("rst_d", {23'd0, d_value}, 3);
    void'(exp_q.pop_back());
    apply_exp--;
    m_pend = 9'd2;
    d_pend = 9'd3;
    repeat (LAT + 4) @(posedge clk50m);
    chk("rst_no_apply", apply_seen, apply_exp);
    go_start();
    wait_done();
    chk("err_final", err_seen, err_exp);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
